// File: rtl/sol_lsu_pkg.sv
// Shared types for the sol load/store unit: FSM states, access widths and
// response fault codes, plus the natural-alignment check used at request time.
package sol_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } lsuState_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE  = 2'b00,
        WIDTH_HALF  = 2'b01,
        WIDTH_WORD  = 2'b10,
        WIDTH_DWORD = 2'b11
    } lsuWidth_t;

    typedef enum logic [1:0] {
        FAULT_NONE          = 2'b00,
        FAULT_MISALIGNED    = 2'b01,
        FAULT_TIMEOUT       = 2'b10,
        FAULT_ILLEGAL_WIDTH = 2'b11
    } lsuFault_t;

    // An access is aligned when the address is a multiple of its size in bytes.
    function automatic logic isMisaligned(input logic [2:0] addrLow, input logic [1:0] width);
        logic bad;
        case (width)
            WIDTH_BYTE: bad = 1'b0;
            WIDTH_HALF: bad = addrLow[0];
            WIDTH_WORD: bad = |addrLow[1:0];
            default:    bad = |addrLow;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sol_lsu_align.sv
// Byte-lane steering for the load/store unit. Stores: byte enables and
// lane-positioned write data. Loads: shift the addressed field down to bit 0,
// keep only the access width and sign- or zero-extend to XLEN.
module sol_lsu_align
    import sol_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int LANES = XLEN / 8,
    localparam int OFF_W = $clog2(LANES)
) (
    input  logic [1:0]       width,
    input  logic [OFF_W-1:0] offset,
    input  logic             loadSigned,
    input  logic [XLEN-1:0]  storeData,
    input  logic [XLEN-1:0]  loadWord,
    output logic [LANES-1:0] byteEnable,
    output logic [XLEN-1:0]  laneData,
    output logic [XLEN-1:0]  loadData
);

    logic [LANES-1:0] laneMask;
    logic [XLEN-1:0]  fieldMask;
    logic [XLEN-1:0]  loadShifted;
    logic             signBit;

    // Lane and field masks for the access width, then position/extract/extend.
    always_comb begin
        laneMask  = '0;
        fieldMask = '0;
        for (int i = 0; i < LANES; i++) begin
            laneMask[i] = (i < (1 << width));
        end
        for (int i = 0; i < XLEN; i++) begin
            fieldMask[i] = (i < (8 << width));
        end

        byteEnable  = laneMask << offset;
        laneData    = storeData << {offset, 3'b000};
        loadShifted = loadWord >> {offset, 3'b000};

        case (width)
            WIDTH_BYTE: signBit = loadShifted[7];
            WIDTH_HALF: signBit = loadShifted[15];
            WIDTH_WORD: signBit = loadShifted[31];
            default:    signBit = loadShifted[XLEN-1];
        endcase

        loadData = (loadShifted & fieldMask) | (~fieldMask & {XLEN{loadSigned & signBit}});
    end

endmodule

// File: rtl/sol_load_store_unit.sv
// Single-outstanding load/store unit for the sol core. Accepts one request in
// IDLE, holds the data-memory bus in ACCESS until the matching completion or a
// timeout, then pulses a one-cycle response in RESPOND. Misaligned and illegal
// width requests skip the bus entirely and respond on the next cycle.
module sol_load_store_unit
    import sol_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [1:0]            ReqWidth,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [XLEN-1:0]       ReqData,
    input  logic [TAG_WIDTH-1:0]  ReqTag,
    output logic                  RespValid,
    output logic [XLEN-1:0]       RespData,
    output logic [TAG_WIDTH-1:0]  RespTag,
    output logic [1:0]            RespFault,
    output logic                  ReadEnable,
    output logic                  WriteEnable,
    output logic [XLEN/8-1:0]     ByteEnable,
    output logic [ADDR_WIDTH-1:0] MemoryAddress,
    output logic [XLEN-1:0]       DataOut,
    input  logic                  ReadComplete,
    input  logic                  WriteComplete,
    input  logic [XLEN-1:0]       DataIn
);

    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_ON = (TIMEOUT_CYCLES != 0);

    lsuState_t        state;
    logic [CNT_W-1:0] timeoutCount;

    // Request fields held for the duration of the access.
    logic             latWrite;
    logic             latSigned;
    logic [1:0]       latWidth;
    logic [OFF_W-1:0] latOffset;

    lsuFault_t        requestFault;
    logic             accessDone;
    logic             timeoutHit;

    logic [1:0]       alignWidth;
    logic [OFF_W-1:0] alignOffset;
    logic [LANES-1:0] alignByteEnable;
    logic [XLEN-1:0]  alignLaneData;
    logic [XLEN-1:0]  alignLoadData;

    // In IDLE the aligner sees the incoming request (store lane placement);
    // afterwards it sees the latched request (load extraction).
    assign alignWidth  = (state == IDLE) ? ReqWidth : latWidth;
    assign alignOffset = (state == IDLE) ? ReqAddress[OFF_W-1:0] : latOffset;

    sol_lsu_align #(
        .XLEN(XLEN)
    ) align (
        .width      (alignWidth),
        .offset     (alignOffset),
        .loadSigned (latSigned),
        .storeData  (ReqData),
        .loadWord   (DataIn),
        .byteEnable (alignByteEnable),
        .laneData   (alignLaneData),
        .loadData   (alignLoadData)
    );

    assign accessDone = latWrite ? WriteComplete : ReadComplete;
    assign timeoutHit = TIMEOUT_ON && (timeoutCount == LAST_COUNT);

    // Classify the incoming request; illegal width takes priority over alignment.
    always_comb begin
        requestFault = FAULT_NONE;
        if ((XLEN < 64) && (ReqWidth == WIDTH_DWORD)) begin
            requestFault = FAULT_ILLEGAL_WIDTH;
        end else if (isMisaligned(ReqAddress[2:0], ReqWidth)) begin
            requestFault = FAULT_MISALIGNED;
        end
    end

    // Capture the request fields needed after acceptance (no reset: data only).
    always_ff @(posedge Clock) begin
        if (state == IDLE && ReqValid) begin
            latWrite  <= ReqWrite;
            latSigned <= ReqSigned;
            latWidth  <= ReqWidth;
            latOffset <= ReqAddress[OFF_W-1:0];
        end
    end

    // Request/response FSM with registered bus and response outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            timeoutCount  <= '0;
            ReqReady      <= 1'b1;
            ReadEnable    <= 1'b0;
            WriteEnable   <= 1'b0;
            ByteEnable    <= '0;
            MemoryAddress <= '0;
            DataOut       <= '0;
            RespValid     <= 1'b0;
            RespData      <= '0;
            RespTag       <= '0;
            RespFault     <= FAULT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        ReqReady <= 1'b0;
                        RespTag  <= ReqTag;
                        if (requestFault != FAULT_NONE) begin
                            state     <= RESPOND;
                            RespValid <= 1'b1;
                            RespData  <= '0;
                            RespFault <= requestFault;
                        end else begin
                            state         <= ACCESS;
                            timeoutCount  <= '0;
                            ReadEnable    <= ~ReqWrite;
                            WriteEnable   <= ReqWrite;
                            MemoryAddress <= {ReqAddress[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            ByteEnable    <= alignByteEnable;
                            DataOut       <= alignLaneData;
                        end
                    end
                end
                ACCESS: begin
                    if (accessDone) begin
                        state       <= RESPOND;
                        ReadEnable  <= 1'b0;
                        WriteEnable <= 1'b0;
                        RespValid   <= 1'b1;
                        RespData    <= latWrite ? '0 : alignLoadData;
                        RespFault   <= FAULT_NONE;
                    end else if (timeoutHit) begin
                        state       <= RESPOND;
                        ReadEnable  <= 1'b0;
                        WriteEnable <= 1'b0;
                        RespValid   <= 1'b1;
                        RespData    <= '0;
                        RespFault   <= FAULT_TIMEOUT;
                    end else begin
                        timeoutCount <= timeoutCount + 1'b1;
                    end
                end
                RESPOND: begin
                    state     <= IDLE;
                    RespValid <= 1'b0;
                    ReqReady  <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    ReadEnable  <= 1'b0;
                    WriteEnable <= 1'b0;
                    RespValid   <= 1'b0;
                    ReqReady    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sol_load_store_unit.sv
// Directed bench for sol_load_store_unit: a 32-bit instance with a short
// timeout carries most scenarios, a 64-bit instance covers dword accesses.
module tb_sol_load_store_unit;
    localparam int TIMEOUT = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    // 32-bit instance signals
    logic        ReqValid = 0, ReqWrite = 0, ReqSigned = 0;
    logic [1:0]  ReqWidth = 0;
    logic [31:0] ReqAddress = 0, ReqData = 0, DataIn = 0;
    logic [3:0]  ReqTag = 0;
    logic        ReadComplete = 0, WriteComplete = 0;
    logic        ReqReady, RespValid, ReadEnable, WriteEnable;
    logic [31:0] RespData, MemoryAddress, DataOut;
    logic [3:0]  RespTag, ByteEnable;
    logic [1:0]  RespFault;

    // 64-bit instance signals
    logic        wReqValid = 0, wReqWrite = 0, wReqSigned = 0;
    logic [1:0]  wReqWidth = 0;
    logic [31:0] wReqAddress = 0;
    logic [63:0] wReqData = 0, wDataIn = 0;
    logic [3:0]  wReqTag = 0;
    logic        wReadComplete = 0, wWriteComplete = 0;
    logic        wReqReady, wRespValid, wReadEnable, wWriteEnable;
    logic [63:0] wRespData, wDataOut;
    logic [31:0] wMemoryAddress;
    logic [3:0]  wRespTag;
    logic [7:0]  wByteEnable;
    logic [1:0]  wRespFault;

    sol_load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TAG_WIDTH(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWrite(ReqWrite), .ReqWidth(ReqWidth), .ReqSigned(ReqSigned),
        .ReqAddress(ReqAddress), .ReqData(ReqData), .ReqTag(ReqTag),
        .RespValid(RespValid), .RespData(RespData), .RespTag(RespTag), .RespFault(RespFault),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .ByteEnable(ByteEnable),
        .MemoryAddress(MemoryAddress), .DataOut(DataOut),
        .ReadComplete(ReadComplete), .WriteComplete(WriteComplete), .DataIn(DataIn));

    sol_load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .TAG_WIDTH(4), .TIMEOUT_CYCLES(255)) dut64 (
        .Clock(Clock), .Reset(Reset), .ReqValid(wReqValid), .ReqReady(wReqReady),
        .ReqWrite(wReqWrite), .ReqWidth(wReqWidth), .ReqSigned(wReqSigned),
        .ReqAddress(wReqAddress), .ReqData(wReqData), .ReqTag(wReqTag),
        .RespValid(wRespValid), .RespData(wRespData), .RespTag(wRespTag), .RespFault(wRespFault),
        .ReadEnable(wReadEnable), .WriteEnable(wWriteEnable), .ByteEnable(wByteEnable),
        .MemoryAddress(wMemoryAddress), .DataOut(wDataOut),
        .ReadComplete(wReadComplete), .WriteComplete(wWriteComplete), .DataIn(wDataIn));

    always #5 Clock = ~Clock;

    int compared = 0;
    int mismatched = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (spec rules, plain arithmetic) -------------
    function automatic logic [1:0] modelFault(input int w, input logic [31:0] addr, input int xlen);
        if (w == 3 && xlen == 32) return 2'd3;
        if ((addr % (32'd1 << w)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] modelBE(input int w, input logic [31:0] addr, input int lanes);
        int v;
        v = ((1 << (1 << w)) - 1) << (addr % lanes);
        return v[7:0];
    endfunction

    function automatic logic [63:0] modelLoad(input int w, input bit sgn, input logic [31:0] addr,
                                              input logic [63:0] word, input int xlen);
        longint unsigned v;
        int o, nb;
        o  = int'(addr % (xlen / 8));
        nb = 8 * (1 << w);
        v  = word >> (8 * o);
        if (nb < 64) begin
            v = v % (64'd1 << nb);
            if (sgn && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
        end
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // ---------------- per-cycle expectations and compare process ----------------
    bit          checkEn = 0;
    logic        expReady = 1, expRead = 0, expWrite = 0, expRespValid = 0;
    logic [31:0] expAddr = 0, expDO = 0, expRespData = 0;
    logic [3:0]  expBE = 0, expTag = 0;
    logic [1:0]  expFault = 0;

    logic [31:0] lastRespData = 0, lastMemAddr = 0, lastDO = 0;
    logic [3:0]  lastBE = 0, lastTag = 0;
    logic [1:0]  lastFault = 0;
    int          respCount = 0;
    int          strobeCount = 0;

    always @(negedge Clock) begin
        if (checkEn) begin
            cmp("ReqReady", ReqReady, expReady);
            cmp("ReadEnable", ReadEnable, expRead);
            cmp("WriteEnable", WriteEnable, expWrite);
            cmp("RespValid", RespValid, expRespValid);
            if (expRead || expWrite) begin
                cmp("MemoryAddress", MemoryAddress, expAddr);
                cmp("ByteEnable", ByteEnable, expBE);
                cmp("DataOut", DataOut, expDO);
            end
            if (expRespValid) begin
                cmp("RespData", RespData, expRespData);
                cmp("RespFault", RespFault, expFault);
                cmp("RespTag", RespTag, expTag);
            end
        end
        if (RespValid) begin
            respCount++;
            lastRespData = RespData;
            lastFault    = RespFault;
            lastTag      = RespTag;
        end
        if (ReadEnable || WriteEnable) begin
            strobeCount++;
            lastMemAddr = MemoryAddress;
            lastBE      = ByteEnable;
            lastDO      = DataOut;
        end
    end

    task automatic expectIdle();
        expReady = 1; expRead = 0; expWrite = 0; expRespValid = 0;
    endtask

    // One transaction on the 32-bit unit. k = ACCESS cycle carrying the
    // completion (0 = never). Spurious completions are driven where they must be ignored.
    task automatic runTxn(input bit wr, input int w, input bit sgn, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] tag, input int k,
                          input logic [31:0] din);
        logic [1:0]  f;
        logic [31:0] rd;
        logic [1:0]  rf;
        f  = modelFault(w, addr, 32);
        rd = 0;
        rf = 0;
        @(posedge Clock); #1;
        ReqValid = 1; ReqWrite = wr; ReqWidth = w[1:0]; ReqSigned = sgn;
        ReqAddress = addr; ReqData = data; ReqTag = tag;
        ReadComplete = 1; WriteComplete = 1; DataIn = 32'hDEAD_BEEF;
        expectIdle();
        @(posedge Clock); #1;
        ReqValid = 0; ReqAddress = 32'hFFFF_FFFF; ReqWidth = 2'b11; ReqData = ~data; ReqSigned = ~sgn;
        ReadComplete = 0; WriteComplete = 0;
        if (f != 0) begin
            rf = f;
        end else begin
            expAddr = addr & ~32'd3;
            expBE   = modelBE(w, addr, 4)[3:0];
            expDO   = data << (8 * (addr % 4));
            for (int i = 1; i <= TIMEOUT; i++) begin
                expReady = 0; expRead = !wr; expWrite = wr; expRespValid = 0;
                if (i == k) begin
                    if (wr) WriteComplete = 1;
                    else begin ReadComplete = 1; DataIn = din; end
                end else begin
                    if (wr) ReadComplete = 1;
                    else WriteComplete = 1;
                end
                @(posedge Clock); #1;
                ReadComplete = 0; WriteComplete = 0;
                if (i == k) begin
                    rd = wr ? 32'd0 : modelLoad(w, sgn, addr, {32'd0, din}, 32)[31:0];
                    rf = 0;
                    break;
                end
                if (i == TIMEOUT) rf = 2;
            end
        end
        expReady = 0; expRead = 0; expWrite = 0; expRespValid = 1;
        expRespData = rd; expFault = rf; expTag = tag;
        @(posedge Clock); #1;
        expectIdle();
    endtask

    // One load on the 64-bit unit, completion on the first ACCESS cycle.
    task automatic run64(input int w, input bit sgn, input logic [31:0] addr, input logic [63:0] din,
                         input logic [3:0] tag, output logic [63:0] gotData, output logic [7:0] gotBE);
        @(posedge Clock); #1;
        wReqValid = 1; wReqWrite = 0; wReqWidth = w[1:0]; wReqSigned = sgn;
        wReqAddress = addr; wReqTag = tag; wReqData = 64'h5555_AAAA_5555_AAAA;
        @(posedge Clock); #1;
        wReqValid = 0;
        @(negedge Clock);
        cmp("w ReadEnable", wReadEnable, 1'b1);
        cmp("w MemoryAddress", wMemoryAddress, addr & ~32'd7);
        cmp("w ByteEnable", wByteEnable, modelBE(w, addr, 8));
        gotBE = wByteEnable;
        wReadComplete = 1; wDataIn = din;
        @(posedge Clock); #1;
        wReadComplete = 0;
        @(negedge Clock);
        cmp("w RespValid", wRespValid, 1'b1);
        cmp("w ReadEnable off", wReadEnable, 1'b0);
        cmp("w RespData", wRespData, modelLoad(w, sgn, addr, din, 64));
        cmp("w RespFault", wRespFault, 2'd0);
        cmp("w RespTag", wRespTag, tag);
        gotData = wRespData;
        @(posedge Clock); #1;
        @(negedge Clock);
        cmp("w RespValid drop", wRespValid, 1'b0);
        cmp("w ReqReady back", wReqReady, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          saved;
        logic [63:0] g64;
        logic [7:0]  be64;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        cmp("rst ReqReady", ReqReady, 1'b1);
        cmp("rst ReadEnable", ReadEnable, 1'b0);
        cmp("rst WriteEnable", WriteEnable, 1'b0);
        cmp("rst RespValid", RespValid, 1'b0);
        cmp("rst RespData", RespData, 32'd0);
        cmp("rst RespFault", RespFault, 2'd0);
        cmp("rst RespTag", RespTag, 4'd0);
        cmp("rst ByteEnable", ByteEnable, 4'd0);
        cmp("rst MemoryAddress", MemoryAddress, 32'd0);
        cmp("rst DataOut", DataOut, 32'd0);
        cmp("rst w ReqReady", wReqReady, 1'b1);
        @(posedge Clock); #1;
        Reset = 0;
        expectIdle();
        checkEn = 1;

        // 1: signed byte load at 0x1003
        runTxn(0, 0, 1, 32'h1003, 32'h0, 4'h1, 1, 32'h80FF_FFFF);
        cmp("t1 RespData lit", lastRespData, 32'hFFFF_FF80);
        cmp("t1 MemoryAddress lit", lastMemAddr, 32'h1000);
        cmp("t1 ByteEnable lit", lastBE, 4'b1000);

        // 2: half store at 0x2002, completes on 3rd ACCESS cycle
        saved = strobeCount;
        runTxn(1, 1, 0, 32'h2002, 32'h1234_ABCD, 4'h2, 3, 32'h0);
        cmp("t2 DataOut lit", lastDO, 32'hABCD_0000);
        cmp("t2 ByteEnable lit", lastBE, 4'b1100);
        cmp("t2 strobe cycles", strobeCount - saved, 3);
        cmp("t2 RespData lit", lastRespData, 32'd0);

        // 3: misaligned word load
        saved = strobeCount;
        runTxn(0, 2, 0, 32'h3001, 32'h0, 4'h7, 1, 32'h1111_1111);
        cmp("t3 fault lit", lastFault, 2'b01);
        cmp("t3 tag lit", lastTag, 4'h7);
        cmp("t3 no strobe", strobeCount - saved, 0);

        // 4: timeout, then completion on the expiry cycle
        saved = strobeCount;
        runTxn(0, 2, 0, 32'h6000, 32'h0, 4'h3, 0, 32'h0);
        cmp("t4 timeout fault lit", lastFault, 2'b10);
        cmp("t4 strobe cycles", strobeCount - saved, TIMEOUT);
        runTxn(0, 2, 0, 32'h6004, 32'h0, 4'h4, TIMEOUT, 32'hCAFE_F00D);
        cmp("t4 late data lit", lastRespData, 32'hCAFE_F00D);
        cmp("t4 late fault lit", lastFault, 2'b00);

        // Extra patterns: byte store at odd lane, signed half load, unsigned byte load
        runTxn(1, 0, 0, 32'h7001, 32'h1234_56AB, 4'h5, 2, 32'h0);
        cmp("x byte store DataOut lit", lastDO, 32'h3456_AB00);
        runTxn(0, 1, 1, 32'h0802, 32'h0, 4'h6, 2, 32'h8000_1234);
        cmp("x signed half lit", lastRespData, 32'hFFFF_8000);
        runTxn(0, 0, 0, 32'h0901, 32'h0, 4'h8, 1, 32'h0000_F100);
        cmp("x unsigned byte lit", lastRespData, 32'h0000_00F1);

        // 5: reset during the 2nd ACCESS cycle of a store
        saved = respCount;
        @(posedge Clock); #1;
        ReqValid = 1; ReqWrite = 1; ReqWidth = 2; ReqSigned = 0;
        ReqAddress = 32'h5000; ReqData = 32'h1122_3344; ReqTag = 4'h9;
        expectIdle();
        @(posedge Clock); #1;
        ReqValid = 0;
        expReady = 0; expRead = 0; expWrite = 1; expRespValid = 0;
        expAddr = 32'h5000; expBE = 4'hF; expDO = 32'h1122_3344;
        @(posedge Clock); #1;
        Reset = 1;
        #1;
        cmp("t5 async WriteEnable drop", WriteEnable, 1'b0);
        cmp("t5 async ReqReady", ReqReady, 1'b1);
        expectIdle();
        @(posedge Clock); #1;
        Reset = 0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        cmp("t5 no response", respCount - saved, 0);
        runTxn(0, 1, 0, 32'h4002, 32'h0, 4'hB, 1, 32'h8001_0000);
        cmp("t5 half load lit", lastRespData, 32'h0000_8001);

        // 6: illegal width on 32-bit, dword accesses on 64-bit
        saved = strobeCount;
        runTxn(0, 3, 0, 32'h2000, 32'h0, 4'hA, 1, 32'h0);
        cmp("t6 illegal fault lit", lastFault, 2'b11);
        cmp("t6 illegal no strobe", strobeCount - saved, 0);
        run64(3, 0, 32'h8, 64'h0123_4567_89AB_CDEF, 4'hC, g64, be64);
        cmp("t6 dword data lit", g64, 64'h0123_4567_89AB_CDEF);
        cmp("t6 dword BE lit", be64, 8'hFF);
        run64(2, 1, 32'hC, 64'h8000_0001_0000_0000, 4'hD, g64, be64);
        cmp("t6 signed word lit", g64, 64'hFFFF_FFFF_8000_0001);
        cmp("t6 upper word BE lit", be64, 8'hF0);

        @(posedge Clock); #1;
        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sol_load_store_unit.md
Name: sol_load_store_unit

Overview:
Parametrised memory-access unit for the sol core family, replacing clock-gated stalling on ReadComplete/WriteComplete with an explicit request/response FSM.
- Accepts one load/store from the execute stage.
- Drives the data-memory bus with byte-lane enables, holding it until completion or timeout.
- Returns aligned, sign/zero-extended load data tagged with the destination register.
- Sits between core execute/writeback and the data-memory port; core stalls on ReqReady.

Parameters:
XLEN, 32, data width in bits (32 or 64).
ADDR_WIDTH, 32, byte-address width.
TAG_WIDTH, 4, destination-register tag width.
TIMEOUT_CYCLES, 255, max ACCESS cycles before a timeout fault; 0 disables the timeout.

Ports:
Clock  in  1  core clock
Reset  in  1  asynchronous, active-high reset
ReqValid  in  1  request present
ReqReady  out  1  unit can accept a request this cycle
ReqWrite  in  1  1 = store, 0 = load
ReqWidth  in  2  00 byte, 01 half, 10 word, 11 dword
ReqSigned  in  1  sign-extend load result
ReqAddress  in  ADDR_WIDTH  byte address
ReqData  in  XLEN  store data, LSB-justified
ReqTag  in  TAG_WIDTH  destination-register tag
RespValid  out  1  single-cycle response pulse
RespData  out  XLEN  extended load data; 0 for stores and faults
RespTag  out  TAG_WIDTH  tag of the completed request
RespFault  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal width
ReadEnable  out  1  memory read strobe
WriteEnable  out  1  memory write strobe
ByteEnable  out  XLEN/8  active byte lanes
MemoryAddress  out  ADDR_WIDTH  address aligned down to XLEN/8
DataOut  out  XLEN  lane-positioned store data
ReadComplete  in  1  read finished; DataIn valid this cycle
WriteComplete  in  1  write accepted
DataIn  in  XLEN  read data, full bus word

Behaviour:
- Reset (async, active-high): state IDLE, timeout counter 0, all outputs 0 except ReqReady=1. Reset asserted during ACCESS drops ReadEnable/WriteEnable immediately. No RespValid is produced for the aborted request.
- States:
  - IDLE: ReqReady=1.
  - ACCESS: bus held.
  - RESPOND: RespValid=1 for exactly one cycle.
- IDLE transitions on ReqValid (ReqReady=1), latching all Req* fields:
  - Width 11 with XLEN=32 -> RESPOND, fault 11.
  - Address not multiple of 2^ReqWidth -> RESPOND, fault 01.
  - Otherwise -> ACCESS.
  - Fault paths never assert a memory strobe.
- ACCESS:
  - Exactly one strobe high; MemoryAddress, ByteEnable and DataOut are registered and stable for the whole state.
  - Lane offset o = ReqAddress mod (XLEN/8).
  - ByteEnable = (2^(2^ReqWidth) - 1) << o.
  - DataOut = ReqData << 8*o.
  - On ReadComplete (load) or WriteComplete (store): register the result and go to RESPOND. Load data = (DataIn >> 8*o), masked to the access width, then sign-extended if ReqSigned else zero-extended.
  - Completion of the wrong kind is ignored.
  - Completion seen in IDLE or RESPOND is ignored.
- Timeout: counter clears on ACCESS entry and increments each ACCESS cycle without completion. When it reaches TIMEOUT_CYCLES (nonzero): deassert the strobe and go to RESPOND with fault 10. Completion arriving in the same cycle as expiry wins (fault 00).
- RESPOND: ReqReady=0, strobes 0, RespTag = latched tag. Unconditionally -> IDLE next cycle.
- Latency: request accepted in cycle N; strobe high from N+1; completion in cycle N+k gives RespValid in N+k+1. Minimum 2 cycles. Faults give RespValid at N+1.
- Throughput: one outstanding request; next acceptance no earlier than the cycle after RespValid.

Decomposition:
- Package sol_lsu_pkg: state enum (IDLE, ACCESS, RESPOND), width enum, fault enum with the codes above.
- Sub-module sol_lsu_align: combinational lane logic producing ByteEnable and DataOut from width/offset/data, and extracting/extending load data. Parametrised by XLEN and shared by both directions.

Test Plan:
1. XLEN=32, signed byte load at 0x1003, ReadComplete on first ACCESS cycle with DataIn=0x80FF_FFFF -> ReadEnable one cycle, MemoryAddress=0x1000, ByteEnable=1000, RespData=0xFFFF_FF80, RespFault=00, RespValid two cycles after acceptance.
2. Half store at 0x2002, ReqData=0x1234_ABCD, WriteComplete after 3 cycles -> WriteEnable held 3 cycles, ByteEnable=1100, DataOut=0xABCD_0000 stable throughout, then RespValid with RespData=0, fault 00.
3. Word load at 0x3001 -> no strobe ever, RespValid next cycle with fault 01, RespTag echoed; ReqReady back high the following cycle.
4. TIMEOUT_CYCLES=4, load with no ReadComplete -> ReadEnable high exactly 4 cycles, then RespValid with fault 10. Repeat with ReadComplete on cycle 4 -> fault 00 and data returned.
5. Reset asserted on 2nd ACCESS cycle of a store -> WriteEnable low asynchronously, no RespValid, ReqReady=1 after release; a following unsigned half load at 0x4002 with DataIn=0x8001_0000 returns 0x0000_8001.
6. Width 11 with XLEN=32 -> fault 11, no strobe. With XLEN=64, dword load at 0x8 with DataIn=0x0123_4567_89AB_CDEF -> ByteEnable=0xFF, RespData=0x0123_4567_89AB_CDEF.
